// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encodings, the
// default operand width and a helper that sizes the bit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter has to hold WIDTH itself: it increments once more on the
    // final RUN cycle. Hence clog2(WIDTH)+1 bits.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Structural full adder for the serial adder, built from the gate library
// primitives: two half adders plus an OR gate that merges their carries.
//   half_adder : a, b        -> s, c
//   or_gate    : a, b        -> y
//   full_adder : a, b, c_in  -> s, c_out
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),    .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(c_in), .s(s),  .c(c1));
    or_gate    u_or  (.a(c0), .b(c1),   .y(c_out));
endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: captures two WIDTH-bit operands on an accepted start and
// adds them LSB-first, one bit per clock, through a single full adder with a
// carry flop chaining the bits. Result is ready WIDTH+1 cycles after start.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port; with
// sub=1 the operation becomes a - b (b inverted, carry seeded with 1).
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request an operation (sampled only in IDLE)
//   sub    subtract select, captured with operands (SERIAL_ADDER_SUB_EN only)
//   a, b   WIDTH-bit operands, captured when start is accepted
//   busy   high in RUN and DONE
//   done   one-cycle pulse, sum/c_out valid
//   sum    WIDTH-bit result register
//   c_out  carry out of the MSB (for subtract: 1 = no borrow)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last_bit;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand/result shift registers, carry and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr <= a;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b = a + ~b + 1: invert b, seed the carry with 1
                    b_sr  <= sub ? ~b : b;
                    carry <= sub;
`else
                    b_sr  <= b;
                    carry <= 1'b0;
`endif
                    cnt  <= '0;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    // new bit enters at the MSB so the result ends up in
                    // natural order after WIDTH shifts (also valid for WIDTH=1)
                    sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_sr;
    assign c_out = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results (value,
// carry, done cycle) into queues; monitors on the falling edge pop and compare
// whenever a DUT raises done. An 8-bit and a 1-bit instance are exercised.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       co;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    // 8-bit instance
    logic       start, sub;
    logic [7:0] a, b, sum;
    logic       busy, done, c_out;
    // 1-bit instance
    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, c_out1;

    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // 8-bit monitor
    logic prev_done8 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done8) check("busy_after_done8", int'(busy), 0);
            if (done) begin
                if (q8.size() == 0) begin
                    check("unexpected_done8", 1, 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("sum8", int'(sum), int'(e.sum));
                    check("c_out8", int'(c_out), int'(e.co));
                    check("done_cycle8", cyc, e.cyc);
                    check("busy_in_done8", int'(busy), 1);
                end
            end
        end
        prev_done8 <= done;
    end

    // 1-bit monitor
    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sum1", int'(sum1), int'(e.sum));
                check("c_out1", int'(c_out1), int'(e.co));
                check("done_cycle1", cyc, e.cyc);
            end
        end
    end

    // Wait for IDLE, then present one operation for one cycle.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic [7:0] esum, input logic eco);
        int n = 0;
        exp_t e;
        @(posedge clk); #1;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout8", 1, 0);
        a = ia; b = ib; sub = isub; start = 1'b1;
        e.sum = esum; e.co = eco; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic op1(input logic ia, input logic ib, input logic esum, input logic eco);
        exp_t e;
        @(posedge clk); #1;
        a1 = ia; b1 = ib; start1 = 1'b1;
        e.sum = {7'd0, esum}; e.co = eco; e.cyc = cyc + 1 + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_c_out", int'(c_out), 0);
        rst = 1'b0;

        // basic adds, incl. back-to-back and carry out
        op8(8'd3,   8'd5,   1'b0, 8'h08, 1'b0);
        op8(8'hFF,  8'h01,  1'b0, 8'h00, 1'b1);
        op8(8'hAA,  8'h55,  1'b0, 8'hFF, 1'b0);
        op8(8'h80,  8'h80,  1'b0, 8'h00, 1'b1);

        // start held high: second operands ignored during RUN/DONE,
        // re-trigger happens from IDLE with whatever is on a/b then
        begin
            exp_t e;
            @(posedge clk); #1;
            while (busy) begin @(posedge clk); #1; end
            a = 8'd10; b = 8'd20; start = 1'b1;
            e.sum = 8'h1E; e.co = 1'b0; e.cyc = cyc + 9;
            q8.push_back(e);
            e.sum = 8'h64; e.co = 1'b0; e.cyc = cyc + 19;
            q8.push_back(e);
            @(posedge clk); #1;
            a = 8'd99; b = 8'd1;
            repeat (10) @(posedge clk);
            #1;
            start = 1'b0;
        end

        // reset in the middle of a RUN aborts without a done pulse
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q8.delete();
        @(posedge clk); #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_c_out", int'(c_out), 0);
        rst = 1'b0;
        repeat (14) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0);
        op8(8'd7, 8'd5, 1'b1, 8'h02, 1'b1);
`endif

        // 1-bit instance
        op1(1'b1, 1'b1, 1'b0, 1'b1);
        op1(1'b1, 1'b0, 1'b1, 1'b0);

        // drain
        begin
            int n = 0;
            while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
                @(posedge clk);
                n++;
            end
            check("queue_drained", q8.size() + q1.size(), 0);
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
